// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU control sequencer: opcode constants,
//   the sequencer state enumeration and the decoded control-word record.
//   No ports; imported by alu_seq_decode and alu_control_sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDA    = 4'h1;
  localparam logic [3:0] OP_LDB    = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_OUTA   = 4'h5;
  localparam logic [3:0] OP_OUTBUS = 4'h6;
  localparam logic [3:0] OP_SKZ    = 4'h7;
  localparam logic [3:0] OP_SKC    = 4'h8;
  localparam logic [3:0] OP_TAB    = 4'h9;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_HALT = 3'd4
  } seq_state_t;

  // Active-high intent bits; the top module converts the load strobes to
  // the active-low datapath polarity when it registers them.
  typedef struct packed {
    logic load_a;     // T2: load register A
    logic load_b;     // T2: load register B
    logic en_a;       // T2: register A onto bus
    logic en_u;       // T2: ALU result onto bus
    logic sub;        // T1..T3: ALU subtract
    logic upd_flags;  // end of T3: capture carry/zero
    logic bus_set;    // T3: output shows bus
    logic bus_clr;    // T3: output shows register A
    logic skip_z;     // end of T3: arm skip if zero flag set
    logic skip_c;     // end of T3: arm skip if carry flag set
    logic halt;       // T3 -> HALT
    logic illegal;    // unknown opcode
  } ctrl_word_t;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode
//   Purely combinational opcode decoder.
//   Ports:
//     op   in  4  opcode to decode
//     word out    decoded control word (ctrl_word_t)
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0]  op,
  output ctrl_word_t  word
);

  always_comb begin
    word = '0;
    case (op)
      OP_NOP:    ;
      OP_LDA:    word.load_a = 1'b1;
      OP_LDB:    word.load_b = 1'b1;
      OP_ADD: begin
        word.en_u      = 1'b1;
        word.load_a    = 1'b1;
        word.upd_flags = 1'b1;
      end
      OP_SUB: begin
        word.en_u      = 1'b1;
        word.load_a    = 1'b1;
        word.sub       = 1'b1;
        word.upd_flags = 1'b1;
      end
      OP_OUTA:   word.bus_clr = 1'b1;
      OP_OUTBUS: word.bus_set = 1'b1;
      OP_SKZ:    word.skip_z  = 1'b1;
      OP_SKC:    word.skip_c  = 1'b1;
      OP_TAB: begin
        word.en_a   = 1'b1;
        word.load_b = 1'b1;
      end
      OP_HLT:    word.halt    = 1'b1;
      default:   word.illegal = 1'b1;  // 0xA..0xE behave as NOP
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer
//   Four-phase (IDLE/T1/T2/T3) control sequencer for a small accumulator
//   datapath, with HALT as a terminal state. All control outputs come
//   straight from flops: each is loaded with the value belonging to the
//   state being entered, so nothing combinational reaches the datapath.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     instr_valid/op/ready  instruction handshake (ready only in IDLE)
//     cf_in, zf_in          datapath flags, sampled at the end of T3
//     ctrl_*                datapath control word (nla/nlb active low)
//     done, skipped         retire pulses (in T3)
//     cf_q, zf_q            latched flags
//     illegal               sticky unknown-opcode indication
//     halted                sequencer stopped by HLT
module alu_control_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [3:0] instr_op,
  output logic       instr_ready,
  input  logic       cf_in,
  input  logic       zf_in,
  output logic       ctrl_bus_sel,
  output logic       ctrl_nla,
  output logic       ctrl_nlb,
  output logic       ctrl_ea,
  output logic       ctrl_eu,
  output logic       ctrl_sub,
  output logic       done,
  output logic       skipped,
  output logic       cf_q,
  output logic       zf_q,
  output logic       illegal,
  output logic       halted
);

  seq_state_t state_reg, state_next;
  logic [3:0] op_reg, op_next;
  logic       skip_armed_reg, skip_armed_next;    // set by a taken SKZ/SKC
  logic       skip_active_reg, skip_active_next;  // current instr is skipped
  logic       nla_reg, nla_next, nlb_reg, nlb_next;
  logic       ea_reg, ea_next, eu_reg, eu_next, sub_reg, sub_next;
  logic       bus_sel_reg, bus_sel_next;
  logic       done_reg, done_next, skipped_reg, skipped_next;
  logic       cf_reg, cf_next, zf_reg, zf_next;
  logic       illegal_reg, illegal_next, halted_reg, halted_next;

  logic       accept;
  logic       skip_eff;
  logic       busy_next;
  logic [3:0] dec_op;
  ctrl_word_t word, word_eff;

  // In IDLE the decoder looks at the offered opcode so the T1 control
  // values (ctrl_sub) can be registered on the accepting edge.
  assign dec_op = (state_reg == ST_IDLE) ? instr_op : op_reg;

  alu_seq_decode u_decode (
    .op   (dec_op),
    .word (word)
  );

  assign accept   = instr_valid && (state_reg == ST_IDLE);
  assign skip_eff = (state_reg == ST_IDLE) ? skip_armed_reg : skip_active_reg;
  // A skipped instruction keeps every effect off, including SKZ/SKC
  // re-arming, so skips never chain.
  assign word_eff = skip_eff ? '0 : word;

  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    skip_armed_next  = skip_armed_reg;
    skip_active_next = skip_active_reg;
    bus_sel_next     = bus_sel_reg;
    cf_next          = cf_reg;
    zf_next          = zf_reg;
    illegal_next     = illegal_reg;

    case (state_reg)
      ST_IDLE: if (instr_valid) state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = word_eff.halt ? ST_HALT : ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase

    if (accept) begin
      op_next          = instr_op;
      skip_active_next = skip_armed_reg;
      skip_armed_next  = 1'b0;
      illegal_next     = illegal_reg | word.illegal;
    end

    if (state_reg == ST_T3) begin
      if (word_eff.upd_flags) begin
        cf_next = cf_in;
        zf_next = zf_in;
      end
      if ((word_eff.skip_z && zf_reg) || (word_eff.skip_c && cf_reg))
        skip_armed_next = 1'b1;
    end

    busy_next = (state_next == ST_T1) || (state_next == ST_T2) ||
                (state_next == ST_T3);

    nla_next = !((state_next == ST_T2) && word_eff.load_a);
    nlb_next = !((state_next == ST_T2) && word_eff.load_b);
    ea_next  = (state_next == ST_T2) && word_eff.en_a;
    eu_next  = (state_next == ST_T2) && word_eff.en_u;
    sub_next = busy_next && word_eff.sub;

    if (state_next == ST_T3) begin
      if (word_eff.bus_set)      bus_sel_next = 1'b1;
      else if (word_eff.bus_clr) bus_sel_next = 1'b0;
    end

    done_next    = (state_next == ST_T3);
    skipped_next = (state_next == ST_T3) && skip_eff;
    halted_next  = (state_next == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_NOP;
      skip_armed_reg  <= 1'b0;
      skip_active_reg <= 1'b0;
      nla_reg         <= 1'b1;
      nlb_reg         <= 1'b1;
      ea_reg          <= 1'b0;
      eu_reg          <= 1'b0;
      sub_reg         <= 1'b0;
      bus_sel_reg     <= 1'b0;
      done_reg        <= 1'b0;
      skipped_reg     <= 1'b0;
      cf_reg          <= 1'b0;
      zf_reg          <= 1'b0;
      illegal_reg     <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      skip_armed_reg  <= skip_armed_next;
      skip_active_reg <= skip_active_next;
      nla_reg         <= nla_next;
      nlb_reg         <= nlb_next;
      ea_reg          <= ea_next;
      eu_reg          <= eu_next;
      sub_reg         <= sub_next;
      bus_sel_reg     <= bus_sel_next;
      done_reg        <= done_next;
      skipped_reg     <= skipped_next;
      cf_reg          <= cf_next;
      zf_reg          <= zf_next;
      illegal_reg     <= illegal_next;
      halted_reg      <= halted_next;
    end
  end

  assign instr_ready  = (state_reg == ST_IDLE);
  assign ctrl_nla     = nla_reg;
  assign ctrl_nlb     = nlb_reg;
  assign ctrl_ea      = ea_reg;
  assign ctrl_eu      = eu_reg;
  assign ctrl_sub     = sub_reg;
  assign ctrl_bus_sel = bus_sel_reg;
  assign done         = done_reg;
  assign skipped      = skipped_reg;
  assign cf_q         = cf_reg;
  assign zf_q         = zf_reg;
  assign illegal      = illegal_reg;
  assign halted       = halted_reg;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer
//   Directed bench for alu_control_sequencer. Each instruction is offered
//   on a falling edge; outputs are sampled on the following falling edges
//   (index 1..3 = T1..T3, index 4 = the cycle after T3).
module tb_alu_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] instr_op;
  logic       instr_ready;
  logic       cf_in, zf_in;
  logic       ctrl_bus_sel, ctrl_nla, ctrl_nlb, ctrl_ea, ctrl_eu, ctrl_sub;
  logic       done, skipped, cf_q, zf_q, illegal, halted;

  int errors = 0;
  int checks = 0;

  logic [1:4] tr_nla, tr_nlb, tr_ea, tr_eu, tr_sub;
  logic [1:4] tr_done, tr_skip, tr_bus, tr_ready;

  alu_control_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_op     (instr_op),
    .instr_ready  (instr_ready),
    .cf_in        (cf_in),
    .zf_in        (zf_in),
    .ctrl_bus_sel (ctrl_bus_sel),
    .ctrl_nla     (ctrl_nla),
    .ctrl_nlb     (ctrl_nlb),
    .ctrl_ea      (ctrl_ea),
    .ctrl_eu      (ctrl_eu),
    .ctrl_sub     (ctrl_sub),
    .done         (done),
    .skipped      (skipped),
    .cf_q         (cf_q),
    .zf_q         (zf_q),
    .illegal      (illegal),
    .halted       (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Offer one instruction and record T1..T3 plus the following cycle.
  // cf/zf are presented during T3.
  task automatic run_op(input logic [3:0] op, input logic cf,
                        input logic zf);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) instr_valid = 1'b0;
      if (i == 3) begin
        cf_in = cf;
        zf_in = zf;
      end
      tr_nla[i]   = ctrl_nla;
      tr_nlb[i]   = ctrl_nlb;
      tr_ea[i]    = ctrl_ea;
      tr_eu[i]    = ctrl_eu;
      tr_sub[i]   = ctrl_sub;
      tr_done[i]  = done;
      tr_skip[i]  = skipped;
      tr_bus[i]   = ctrl_bus_sel;
      tr_ready[i] = instr_ready;
    end
  endtask

  function automatic logic [12:0] out_vec();
    return {instr_ready, ctrl_nla, ctrl_nlb, ctrl_ea, ctrl_eu, ctrl_sub,
            ctrl_bus_sel, done, skipped, cf_q, zf_q, illegal, halted};
  endfunction

  initial begin
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 4'h0;
    cf_in       = 1'b0;
    zf_in       = 1'b0;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", 32'(out_vec()), 32'h1C00);
    @(negedge clk);
    check("reset_hold", 32'(out_vec()), 32'h1C00);
    rst_n = 1'b1;

    // LDA, LDB, ADD (cf=0, zf=1 in ADD T3)
    run_op(4'h1, 1'b0, 1'b0);
    check("lda_nla", 32'(tr_nla), 32'hB);       // 1011
    check("lda_eu", 32'(tr_eu), 32'h0);
    check("lda_done", 32'(tr_done), 32'h2);     // done in T3 only
    check("lda_ready", 32'(tr_ready), 32'h1);   // ready again after T3
    run_op(4'h2, 1'b0, 1'b0);
    check("ldb_nlb", 32'(tr_nlb), 32'hB);
    check("ldb_nla", 32'(tr_nla), 32'hF);
    run_op(4'h3, 1'b0, 1'b1);
    check("add_nla", 32'(tr_nla), 32'hB);
    check("add_eu", 32'(tr_eu), 32'h4);
    check("add_done", 32'(tr_done), 32'h2);
    check("add_flags", 32'({cf_q, zf_q}), 32'h1);

    // SUB with cf=1, zf=0
    run_op(4'h4, 1'b1, 1'b0);
    check("sub_sub", 32'(tr_sub), 32'hE);       // 1110
    check("sub_eu", 32'(tr_eu), 32'h4);
    check("sub_nla", 32'(tr_nla), 32'hB);
    check("sub_flags", 32'({cf_q, zf_q}), 32'h2);

    // TAB
    run_op(4'h9, 1'b0, 1'b0);
    check("tab_ea_nlb", 32'({tr_ea, tr_nlb}), 32'h4B);
    check("tab_flags_kept", 32'({cf_q, zf_q}), 32'h2);

    // SKZ with zf_q=1 skips the following LDB
    run_op(4'h3, 1'b0, 1'b1);
    run_op(4'h7, 1'b0, 1'b0);
    check("skz_quiet", 32'({tr_nla, tr_nlb, tr_done, tr_skip}), 32'hFF20);
    run_op(4'h2, 1'b0, 1'b0);
    check("skipped_ldb_nlb", 32'(tr_nlb), 32'hF);
    check("skipped_ldb_pulse", 32'({tr_done, tr_skip}), 32'h22);
    run_op(4'h2, 1'b0, 1'b0);
    check("ldb_after_skip", 32'({tr_nlb, tr_skip}), 32'hB0);

    // Skips do not chain: skipped SKZ must not re-arm
    run_op(4'h7, 1'b0, 1'b0);
    run_op(4'h7, 1'b0, 1'b0);
    check("skz_skipped", 32'(tr_skip), 32'h2);
    run_op(4'h1, 1'b0, 1'b0);
    check("no_chain_lda", 32'({tr_nla, tr_skip}), 32'hB0);

    // OUTBUS, NOP, OUTA
    run_op(4'h6, 1'b0, 1'b0);
    check("outbus_bus", 32'(tr_bus), 32'h3);    // 0011
    run_op(4'h0, 1'b0, 1'b0);
    check("nop_bus", 32'(tr_bus), 32'hF);
    run_op(4'h5, 1'b0, 1'b0);
    check("outa_bus", 32'(tr_bus), 32'hC);      // 1100

    // Illegal opcode, then HLT, then LDA offered
    run_op(4'hC, 1'b1, 1'b1);
    check("illegal_nop", 32'({tr_nla, tr_nlb, tr_eu}), 32'hFF0);
    check("illegal_flag", 32'({illegal, cf_q, zf_q}), 32'h5);
    run_op(4'hF, 1'b0, 1'b0);
    check("hlt_done", 32'(tr_done), 32'h2);
    check("hlt_state", 32'({halted, instr_ready}), 32'h2);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_blocks", 32'({instr_ready, ctrl_nla, done, halted}), 32'h5);
    end
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("halt_reset", 32'(out_vec()), 32'h1C00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during ADD T2
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 4'h3;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("add_t2_active", 32'({ctrl_nla, ctrl_eu}), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("abort_async", 32'({ctrl_nla, ctrl_eu, instr_ready}), 32'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'({done, ctrl_nla, ctrl_eu}), 32'h2);
    end
    rst_n = 1'b1;
    run_op(4'h1, 1'b0, 1'b0);
    check("post_abort_lda", 32'({tr_nla, tr_done}), 32'hB2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-002 SHALL provide these ports:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  instr_valid  in  1  instruction offered
  instr_op  in  4  opcode
  instr_ready  out  1  sequencer accepts instruction this cycle
  cf_in  in  1  carry flag from datapath
  zf_in  in  1  zero flag from datapath
  ctrl_bus_sel  out  1  1 = output shows bus, 0 = output shows register A
  ctrl_nla  out  1  load register A, active low
  ctrl_nlb  out  1  load register B, active low
  ctrl_ea  out  1  drive register A onto bus
  ctrl_eu  out  1  drive ALU result onto bus
  ctrl_sub  out  1  ALU subtract
  done  out  1  one-cycle pulse, instruction retired
  skipped  out  1  one-cycle pulse with done, instruction was skipped
  cf_q, zf_q  out  1 each  latched flags
  illegal  out  1  sticky, unknown opcode seen
  halted  out  1  sequencer stopped by HLT

Function
REQ-003 SHALL use the opcodes 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 OUTA, 6 OUTBUS, 7 SKZ, 8 SKC, 9 TAB, F HLT; 10-14 are illegal.
REQ-004 SHALL implement states IDLE, T1, T2, T3 and HALT.
REQ-005 SHALL set instr_ready = 1 only in IDLE; a transfer occurs on instr_valid & instr_ready, which latches instr_op and moves the sequencer to T1.
REQ-006 SHALL step T1->T2->T3->IDLE unconditionally, so done pulses in T3, three cycles after acceptance, and the next acceptance is possible one cycle later.
REQ-007 T1 SHALL drive all controls inactive (nla = 1, nlb = 1, ea = 0, eu = 0), except ctrl_sub, which is set per REQ-009; this cycle is the datapath input-buffer settle cycle.
REQ-008 T2 SHALL drive the control word for exactly one cycle:
  LDA: nla = 0
  LDB: nlb = 0
  ADD: eu = 1, nla = 0
  SUB: eu = 1, nla = 0
  TAB: ea = 1, nlb = 0
  all other opcodes: inactive
REQ-009 SHALL hold ctrl_sub = 1 in T1, T2 and T3 for SUB only; ctrl_sub is 0 otherwise.
REQ-010 SHALL capture cf_in and zf_in into cf_q and zf_q in T3 for ADD and SUB only; other opcodes leave the flags unchanged.
REQ-011 SHALL have OUTA clear and OUTBUS set ctrl_bus_sel in T3; the value holds until changed by another OUTA or OUTBUS.
REQ-012 SKZ (when zf_q = 1) and SKC (when cf_q = 1) SHALL arm a skip bit in T3; otherwise they behave as NOP.
REQ-013 When the skip bit is armed, the next accepted instruction SHALL run T1-T3 with all controls inactive, no flag or bus_sel update and no HLT effect, SHALL pulse skipped with done, and SHALL clear the skip bit.
REQ-014 A skip SHALL NOT chain: a skipped SKZ or SKC does not re-arm the skip bit.
REQ-015 An illegal opcode SHALL execute as NOP and set illegal, which stays set until reset.
REQ-016 HLT SHALL move the sequencer from T3 to HALT, with done pulsing; in HALT, halted = 1, instr_ready = 0 and all controls are inactive until reset.
REQ-017 SHALL drive every control output from flops; there is no combinational path from instr_op, cf_in or zf_in to any control output.

Reset
REQ-018 While rst_n = 0, the outputs SHALL be:
  state IDLE, so instr_ready = 1
  ctrl_nla = 1, ctrl_nlb = 1
  ctrl_ea = 0, ctrl_eu = 0, ctrl_sub = 0, ctrl_bus_sel = 0
  done = 0, skipped = 0, cf_q = 0, zf_q = 0, illegal = 0, halted = 0
  skip bit cleared
REQ-019 Reset asserted mid-instruction SHALL abort the instruction immediately with no done pulse, and no partial control word SHALL persist.

Structure
REQ-020 SHALL place the opcode constants, the state enumeration and the control-word record type in the shared package alu_seq_pkg.
REQ-021 SHALL decode instr_op to a control word in one combinational sub-module, alu_seq_decode; the sequencing flops live in the top module.

Verification
REQ-022 SHALL cover LDA then LDB then ADD, with cf_in = 0 and zf_in = 1 presented in T3: ctrl_nla is low for exactly one cycle in each LDA and ADD T2, ctrl_eu is high only in the ADD T2, zf_q = 1, and done pulses 3 cycles after each acceptance.
REQ-023 SHALL cover SUB: ctrl_sub is high for 3 consecutive cycles and ctrl_eu/ctrl_nla are asserted together in the middle cycle; then cf_in = 1 yields cf_q = 1.
REQ-024 SHALL cover SKZ with zf_q = 1 followed by LDB: LDB produces no ctrl_nlb low and skipped = 1 with done; a following LDB executes normally.
REQ-025 SHALL cover OUTBUS then NOP then OUTA: ctrl_bus_sel rises in the OUTBUS T3, holds through NOP, and falls in the OUTA T3.
REQ-026 SHALL cover opcode 0xC, then HLT, then LDA offered: illegal = 1, halted = 1, instr_ready stays 0 and LDA is never accepted; rst_n low clears everything.
REQ-027 SHALL cover rst_n asserted in an ADD T2: ctrl_nla returns to 1 and ctrl_eu to 0 immediately (asynchronously), with no done pulse.
